alu_operand_collector: RTL and testbench

- Parametrised successor to the single-beat ALU input port.
- Accepts multi-beat operand streams over a narrow bus using the valid/ready/last handshake.
- Assembles each stream into full-width A/B operands plus an opcode, and buffers completed commands in a FIFO toward the multi-cycle ALU core.
- Detects malformed streams (overflow, opcode change mid-stream) and discards them cleanly.

---
 rtl/alu_operand_collector_pkg.sv | 14 +
 rtl/alu_cmd_fifo.sv | 59 +++++
 rtl/alu_operand_collector.sv | 154 +++++++++++++++
 tb/tb_alu_operand_collector.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_collector_pkg.sv
// Shared definitions for the ALU operand collector.
// Holds the default bus geometry and the stream error codes.
package alu_operand_collector_pkg;

  localparam int OPERAND_BUS_WIDTH = 8;
  localparam int MAX_OPERAND_BEATS = 4;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_OVF   = 2'b01,
    ERR_OPMIS = 2'b10
  } err_code_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Parametrised synchronous FIFO with registered full/empty flags.
// The head entry is presented combinationally on rdata.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = 1;
  localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: combinational blocks assign a default first so no path leaves a value held (no latch).
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CNT_ONE;
    else if (do_pop && !do_push) count_nxt = count - CNT_ONE;
  end

  // NOTE: storage is reset so the head outputs read as zero after reset; cheap at this depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/alu_operand_collector.sv
// Collects multi-beat operand streams into full-width ALU commands and queues them.
// Optional saturating command/error counters are enabled with ALU_COLLECT_STATS_EN.
module alu_operand_collector
  import alu_operand_collector_pkg::*;
#(
  parameter int BUS_W     = OPERAND_BUS_WIDTH,
  parameter int MAX_BEATS = MAX_OPERAND_BEATS,
  parameter int DEPTH     = 2,
  parameter int OP_W      = 3,
  localparam int OPW      = BUS_W * MAX_BEATS,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             operand_valid,
  input  logic [OP_W-1:0]  op,
  input  logic [BUS_W-1:0] a,
  input  logic [BUS_W-1:0] b,
  input  logic             operand_last,
  output logic             ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [OP_W-1:0]  cmd_op,
  output logic [OPW-1:0]   cmd_a,
  output logic [OPW-1:0]   cmd_b,
  output logic [CNT_W-1:0] cmd_beats,
  output logic             err,
`ifdef ALU_COLLECT_STATS_EN
  output logic [1:0]       err_code,
  output logic [15:0]      stat_cmds,
  output logic [15:0]      stat_errs
`else
  output logic [1:0]       err_code
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [OPW-1:0]   a;
    logic [OPW-1:0]   b;
    logic [CNT_W-1:0] beats;
  } cmd_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  state_e           state, state_nxt;
  logic [OPW-1:0]   asm_a, asm_b, nxt_a, nxt_b;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] cnt_q, slot, nxt_cnt;
  logic             alive, accept, stream_err, wr_beat, push;
  logic             fifo_full, fifo_empty;
  err_code_e        err_kind, err_code_q;
  cmd_t             push_cmd, head_cmd;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !operand_last) state_nxt = COLLECT;
      COLLECT: if (accept) begin
                 if (operand_last)    state_nxt = IDLE;
                 else if (stream_err) state_nxt = DROP;
               end
      DROP:    if (accept && operand_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decode of the current beat: handshake, error classification and the assembled next value.
  always_comb begin
    ready      = alive && ((state == DROP) || !fifo_full);
    accept     = operand_valid && ready;
    stream_err = accept && (state == COLLECT) && ((op != op_q) || (cnt_q == CNT_MAX));
    err_kind   = (op != op_q) ? ERR_OPMIS : ERR_OVF;
    wr_beat    = accept && ((state == IDLE) || ((state == COLLECT) && !stream_err));
    push       = wr_beat && operand_last;
    slot       = (state == IDLE) ? '0 : cnt_q;
    nxt_a      = (state == IDLE) ? '0 : asm_a;
    nxt_b      = (state == IDLE) ? '0 : asm_b;
    if (wr_beat) begin
      nxt_a[slot*BUS_W +: BUS_W] = a;
      nxt_b[slot*BUS_W +: BUS_W] = b;
    end
    nxt_cnt    = slot + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive      <= 1'b0;
      asm_a      <= '0;
      asm_b      <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      alive <= 1'b1;
      err   <= stream_err;
      if (stream_err) err_code_q <= err_kind;
      if (wr_beat) begin
        asm_a <= nxt_a;
        asm_b <= nxt_b;
        cnt_q <= nxt_cnt;
        if (state == IDLE) op_q <= op;
      end
    end
  end

  // An error-free beat has op equal to the latched opcode, so the live op is pushed.
  assign push_cmd = '{op: op, a: nxt_a, b: nxt_b, beats: nxt_cnt};

  alu_cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_cmd),
    .pop   (cmd_valid && cmd_ready),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;
  assign cmd_op    = head_cmd.op;
  assign cmd_a     = head_cmd.a;
  assign cmd_b     = head_cmd.b;
  assign cmd_beats = head_cmd.beats;
  assign err_code  = err_code_q;

`ifdef ALU_COLLECT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cmds <= '0;
      stat_errs <= '0;
    end else begin
      if (push && (stat_cmds != 16'hFFFF))       stat_cmds <= stat_cmds + 16'd1;
      if (stream_err && (stat_errs != 16'hFFFF)) stat_errs <= stat_errs + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// Scoreboard bench for alu_operand_collector: directed streams push expected commands/errors,
// a negedge monitor pops and compares whenever the DUT presents a command or an error pulse.
module tb_alu_operand_collector;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  beats;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        operand_valid;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic        operand_last;
  logic        ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_beats;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;

  cmd_t       exp_q[$];
  logic [1:0] err_exp[$];

  alu_operand_collector dut (
    .clk           (clk),
    .rst           (rst),
    .operand_valid (operand_valid),
    .op            (op),
    .a             (a),
    .b             (b),
    .operand_last  (operand_last),
    .ready         (ready),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_beats     (cmd_beats),
    .err           (err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // Monitor: compares whatever the DUT presents against the head of the expectation queues.
  always @(negedge clk) begin
    cmd_t       e;
    logic [1:0] ec;
    if (rst === 1'b1 && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) check("cmd_unexpected", cmd_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("cmd", {cmd_op, cmd_a, cmd_b, cmd_beats}, e);
      end
    end
    if (rst === 1'b1 && err) begin
      if (err_exp.size() == 0) check("err_unexpected", err, 0);
      else begin
        ec = err_exp.pop_front();
        check("err_code", err_code, ec);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the edge that transferred the beat.
  task automatic send_beat(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                           input logic l);
    int n = 0;
    operand_valid = 1'b1;
    op = o; a = aa; b = bb; operand_last = l;
    @(negedge clk);
    while (!ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready) begin
      check("beat_timeout", ready, 1);
      operand_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    operand_valid = 1'b0;
    operand_last  = 1'b0;
  endtask

  function automatic cmd_t mk(logic [2:0] o, logic [31:0] aa, logic [31:0] bb, logic [2:0] n);
    cmd_t c;
    c.op = o; c.a = aa; c.b = bb; c.beats = n;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; operand_valid = 1'b0; op = '0; a = '0; b = '0;
    operand_last = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Reset state
    check("rst_ready", ready, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_cmd_fields", {cmd_op, cmd_a, cmd_b, cmd_beats}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", ready, 1);

    // Single beat, one-cycle latency
    exp_q.push_back(mk(3'd3, 32'h12, 32'h34, 3'd1));
    send_beat(3'd3, 8'h12, 8'h34, 1'b1);
    check("single_latency", cmd_valid, 1);
    @(posedge clk); #1;

    // Four beats, little-endian assembly
    exp_q.push_back(mk(3'd1, 32'h44332211, 32'h04030201, 3'd4));
    send_beat(3'd1, 8'h11, 8'h01, 1'b0);
    send_beat(3'd1, 8'h22, 8'h02, 1'b0);
    send_beat(3'd1, 8'h33, 8'h03, 1'b0);
    send_beat(3'd1, 8'h44, 8'h04, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Overflow: five beats without last, then a closing beat
    err_exp.push_back(2'b01);
    for (int i = 0; i < 5; i++) send_beat(3'd4, 8'(8'hA0 + i), 8'(8'hB0 + i), 1'b0);
    send_beat(3'd4, 8'hA5, 8'hB5, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("ovf_no_cmd", cmd_valid, 0);
    check("ovf_code_sticky", err_code, 2'b01);
    // Back in IDLE: a fresh single beat must assemble with zero upper slices
    exp_q.push_back(mk(3'd4, 32'hAB, 32'hCD, 3'd1));
    send_beat(3'd4, 8'hAB, 8'hCD, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Opcode change mid-stream
    err_exp.push_back(2'b10);
    send_beat(3'd2, 8'h01, 8'h02, 1'b0);
    send_beat(3'd5, 8'h03, 8'h04, 1'b0);
    send_beat(3'd2, 8'h05, 8'h06, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("opmis_fifo_unchanged", cmd_valid, 0);
    check("opmis_code_sticky", err_code, 2'b10);

    // Backpressure with DEPTH=2
    cmd_ready = 1'b0;
    exp_q.push_back(mk(3'd1, 32'h01, 32'hA1, 3'd1));
    exp_q.push_back(mk(3'd2, 32'h02, 32'hA2, 3'd1));
    exp_q.push_back(mk(3'd3, 32'h03, 32'hA3, 3'd1));
    send_beat(3'd1, 8'h01, 8'hA1, 1'b1);
    send_beat(3'd2, 8'h02, 8'hA2, 1'b1);
    check("full_ready_low", ready, 0);
    check("full_cmd_valid", cmd_valid, 1);
    operand_valid = 1'b1; op = 3'd3; a = 8'h03; b = 8'hA3; operand_last = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("stall_ready_low", ready, 0);
    check("head_stable", {cmd_op, cmd_a, cmd_b, cmd_beats}, mk(3'd1, 32'h01, 32'hA1, 3'd1));
    cmd_ready = 1'b1;
    send_beat(3'd3, 8'h03, 8'hA3, 1'b1);
    repeat (4) @(posedge clk); #1;
    check("drained", cmd_valid, 0);

    // Reset mid-stream with one entry queued
    cmd_ready = 1'b0;
    send_beat(3'd7, 8'h77, 8'h88, 1'b1);
    send_beat(3'd2, 8'h10, 8'h20, 1'b0);
    send_beat(3'd2, 8'h11, 8'h21, 1'b0);
    check("pre_reset_valid", cmd_valid, 1);
    rst = 1'b0;
    #1;
    check("midrst_cmd_valid", cmd_valid, 0);
    check("midrst_ready", ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_empty", cmd_valid, 0);
    check("post_rst_err_code", err_code, 0);
    exp_q.push_back(mk(3'd6, 32'h05, 32'h06, 3'd1));
    send_beat(3'd6, 8'h05, 8'h06, 1'b1);
    repeat (5) @(posedge clk); #1;

    check("cmds_all_seen", exp_q.size(), 0);
    check("errs_all_seen", err_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
